// File: rtl/pipe_pkg.sv
// Shared types and constants for the pipeline hazard controller.
// Forwarding selects, the data-memory FSM state enum and the zero-register index.
package pipe_pkg;

    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_WB  = 2'b01;
    localparam logic [1:0] FWD_MEM = 2'b10;

    localparam logic [4:0] REG_ZERO = 5'd0;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } mem_state_e;

    // E-stage ALU operand source; the younger M result wins over W.
    function automatic logic [1:0] fwd_sel_e(
        input logic [4:0] src,
        input logic [4:0] dst_m,
        input logic       wr_m,
        input logic [4:0] dst_w,
        input logic       wr_w
    );
        logic [1:0] sel;
        sel = FWD_RF;
        if (src != REG_ZERO && wr_m && src == dst_m)
            sel = FWD_MEM;
        else if (src != REG_ZERO && wr_w && src == dst_w)
            sel = FWD_WB;
        return sel;
    endfunction

    function automatic logic fwd_sel_d(
        input logic [4:0] src,
        input logic [4:0] dst_m,
        input logic       wr_m
    );
        return (src != REG_ZERO) && wr_m && (src == dst_m);
    endfunction

endpackage

// File: rtl/dmem_handshake_fsm.sv
// Data-memory req/ack sequencer for the M stage with a wait-cycle timeout.
// A timed-out access is aborted and recorded in a sticky error flag.
module dmem_handshake_fsm #(
    parameter int TIMEOUT = 64
) (
    input  logic clk,
    input  logic rst_n,
    input  logic memReqM,
    input  logic dmem_ack,
    output logic dmem_req,
    output logic memstall,
    output logic abort,
    output logic mem_err
);
    import pipe_pkg::*;

    localparam int WCNT_W = $clog2(TIMEOUT);
    // The IDLE request cycle plus TIMEOUT-1 WAIT cycles make TIMEOUT request cycles.
    localparam logic [WCNT_W-1:0] WAIT_LAST = WCNT_W'(TIMEOUT - 2);

    mem_state_e        r_state;
    mem_state_e        w_state_next;
    logic [WCNT_W-1:0] r_wcnt;
    logic [WCNT_W-1:0] w_wcnt_next;
    logic              r_err;
    logic              w_req;
    logic              w_abort;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_wcnt  <= '0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_wcnt  <= w_wcnt_next;
            if (w_abort)
                r_err <= 1'b1;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_wcnt_next  = r_wcnt;
        w_req        = 1'b0;
        w_abort      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_req = memReqM;
                if (memReqM && !dmem_ack) begin
                    w_state_next = ST_WAIT;
                    w_wcnt_next  = '0;
                end
            end
            ST_WAIT: begin
                w_req = 1'b1;
                if (dmem_ack) begin
                    w_state_next = ST_IDLE;
                    w_wcnt_next  = '0;
                end else if (r_wcnt == WAIT_LAST) begin
                    w_abort      = 1'b1;
                    w_state_next = ST_IDLE;
                    w_wcnt_next  = '0;
                end else begin
                    w_wcnt_next = r_wcnt + WCNT_W'(1);
                end
            end
            default: begin
                w_state_next = ST_IDLE;
                w_wcnt_next  = '0;
            end
        endcase
    end

    assign dmem_req = w_req;
    assign abort    = w_abort;
    assign memstall = w_req && !dmem_ack && !w_abort;
    assign mem_err  = r_err;

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush/forwarding controller for the 5-stage pipeline.
// Memory wait stalls the whole front; load-use and branch hazards stall F/D only.
module pipe_hazard_ctrl #(
    parameter int TIMEOUT = 64,
    parameter int CNT_W   = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [4:0]       rsD,
    input  logic [4:0]       rtD,
    input  logic [4:0]       rsE,
    input  logic [4:0]       rtE,
    input  logic [4:0]       writeRegE,
    input  logic [4:0]       writeRegM,
    input  logic [4:0]       writeRegW,
    input  logic             regwriteE,
    input  logic             regwriteM,
    input  logic             regwriteW,
    input  logic             memtoregE,
    input  logic             memtoregM,
    input  logic             branchD,
    input  logic             jumpD,
    input  logic             pcSrcD,
    input  logic             memReqM,
    input  logic             dmem_ack,
    output logic             dmem_req,
    output logic             stallF,
    output logic             stallD,
    output logic             stallE,
    output logic             stallM,
    output logic             flushD,
    output logic             flushE,
    output logic             flushW,
    output logic             forwardAD,
    output logic             forwardBD,
    output logic [1:0]       forwardAE,
    output logic [1:0]       forwardBE,
    output logic             mem_err,
    output logic [CNT_W-1:0] stall_cnt
);
    import pipe_pkg::*;

    logic             w_memstall;
    logic             w_abort;
    logic             w_lwstall;
    logic             w_brstall_e;
    logic             w_brstall_m;
    logic             w_brstall;
    logic [CNT_W-1:0] r_stall_cnt;

    dmem_handshake_fsm #(
        .TIMEOUT (TIMEOUT)
    ) u_dmem_fsm (
        .clk      (clk),
        .rst_n    (rst_n),
        .memReqM  (memReqM),
        .dmem_ack (dmem_ack),
        .dmem_req (dmem_req),
        .memstall (w_memstall),
        .abort    (w_abort),
        .mem_err  (mem_err)
    );

    assign w_lwstall   = memtoregE && ((rtE == rsD) || (rtE == rtD));
    // The branch compare in D needs operands not yet available from E or a load in M.
    assign w_brstall_e = regwriteE && (writeRegE != REG_ZERO) &&
                         ((writeRegE == rsD) || (writeRegE == rtD));
    assign w_brstall_m = memtoregM && (writeRegM != REG_ZERO) &&
                         ((writeRegM == rsD) || (writeRegM == rtD));
    assign w_brstall   = branchD && (w_brstall_e || w_brstall_m);

    always_comb begin
        stallF = 1'b0;
        stallD = 1'b0;
        stallE = 1'b0;
        stallM = 1'b0;
        flushD = 1'b0;
        flushE = 1'b0;
        flushW = 1'b0;
        if (w_memstall) begin
            stallF = 1'b1;
            stallD = 1'b1;
            stallE = 1'b1;
            stallM = 1'b1;
            flushW = 1'b1;
        end else if (w_abort) begin
            flushW = 1'b1;
        end else if (w_lwstall || w_brstall) begin
            // Redirect is held off: the branch re-resolves once its operands arrive.
            stallF = 1'b1;
            stallD = 1'b1;
            flushE = 1'b1;
        end else if (pcSrcD || jumpD) begin
            flushD = 1'b1;
        end
    end

    assign forwardAE = fwd_sel_e(rsE, writeRegM, regwriteM, writeRegW, regwriteW);
    assign forwardBE = fwd_sel_e(rtE, writeRegM, regwriteM, writeRegW, regwriteW);
    assign forwardAD = fwd_sel_d(rsD, writeRegM, regwriteM);
    assign forwardBD = fwd_sel_d(rtD, writeRegM, regwriteM);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_stall_cnt <= '0;
        else if (stallF && (r_stall_cnt != {CNT_W{1'b1}}))
            r_stall_cnt <= r_stall_cnt + CNT_W'(1);
    end

    assign stall_cnt = r_stall_cnt;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl: hand-derived expectations go through a scoreboard queue.
// Small TIMEOUT and CNT_W make the timeout and counter saturation reachable.
module tb_pipe_hazard_ctrl;

    typedef struct packed {
        logic [3:0] stl;   // stallF, stallD, stallE, stallM
        logic [2:0] fl;    // flushD, flushE, flushW
        logic [1:0] fd;    // forwardAD, forwardBD
        logic [1:0] fae;
        logic [1:0] fbe;
        logic       req;
        logic       err;
        logic [3:0] cnt;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [4:0] rsD, rtD, rsE, rtE, writeRegE, writeRegM, writeRegW;
    logic       regwriteE, regwriteM, regwriteW, memtoregE, memtoregM;
    logic       branchD, jumpD, pcSrcD, memReqM, dmem_ack;
    logic       dmem_req, stallF, stallD, stallE, stallM, flushD, flushE, flushW;
    logic       forwardAD, forwardBD, mem_err;
    logic [1:0] forwardAE, forwardBE;
    logic [3:0] stall_cnt;

    exp_t  sb_q[$];
    string tag_q[$];
    int    n_assert = 0;
    int    n_fail   = 0;
    logic [3:0] exp_cnt = 4'd0;
    logic       exp_err = 1'b0;

    pipe_hazard_ctrl #(.TIMEOUT(4), .CNT_W(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .rsD(rsD), .rtD(rtD), .rsE(rsE), .rtE(rtE),
        .writeRegE(writeRegE), .writeRegM(writeRegM), .writeRegW(writeRegW),
        .regwriteE(regwriteE), .regwriteM(regwriteM), .regwriteW(regwriteW),
        .memtoregE(memtoregE), .memtoregM(memtoregM),
        .branchD(branchD), .jumpD(jumpD), .pcSrcD(pcSrcD),
        .memReqM(memReqM), .dmem_ack(dmem_ack), .dmem_req(dmem_req),
        .stallF(stallF), .stallD(stallD), .stallE(stallE), .stallM(stallM),
        .flushD(flushD), .flushE(flushE), .flushW(flushW),
        .forwardAD(forwardAD), .forwardBD(forwardBD),
        .forwardAE(forwardAE), .forwardBE(forwardBE),
        .mem_err(mem_err), .stall_cnt(stall_cnt)
    );

    always #5 clk = ~clk;

    task automatic idle_in();
        rsD = 0; rtD = 0; rsE = 0; rtE = 0;
        writeRegE = 0; writeRegM = 0; writeRegW = 0;
        regwriteE = 0; regwriteM = 0; regwriteW = 0;
        memtoregE = 0; memtoregM = 0;
        branchD = 0; jumpD = 0; pcSrcD = 0;
        memReqM = 0; dmem_ack = 0;
    endtask

    task automatic check_out();
        exp_t  e, obs;
        string t;
        e   = sb_q.pop_front();
        t   = tag_q.pop_front();
        obs = {stallF, stallD, stallE, stallM, flushD, flushE, flushW,
               forwardAD, forwardBD, forwardAE, forwardBE, dmem_req, mem_err, stall_cnt};
        n_assert++;
        assert (obs === e) else begin
            n_fail++;
            $error("FAIL %s observed=%b required=%b (stl fl fd fae fbe req err cnt)", t, obs, e);
        end
    endtask

    // Inputs are already driven; push the expectation, compare on the falling edge,
    // then advance to just after the next rising edge.
    task automatic step(input string t, input logic [3:0] stl, input logic [2:0] fl,
                        input logic [1:0] fd, input logic [1:0] fae, input logic [1:0] fbe,
                        input logic req);
        exp_t e;
        e = '{stl: stl, fl: fl, fd: fd, fae: fae, fbe: fbe, req: req, err: exp_err, cnt: exp_cnt};
        sb_q.push_back(e);
        tag_q.push_back(t);
        @(negedge clk);
        check_out();
        if (stl[3] && rst_n && exp_cnt != 4'hF)
            exp_cnt = exp_cnt + 4'd1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        idle_in();
        rst_n = 1'b0;
        step("reset", 4'b0000, 3'b000, 2'b00, 2'b00, 2'b00, 1'b0);
        rst_n = 1'b1;
        step("idle", 4'b0000, 3'b000, 2'b00, 2'b00, 2'b00, 1'b0);

        // Load-use on rs, then the loaded value comes from W.
        memtoregE = 1; rtE = 5; rsD = 5;
        step("lu_rs", 4'b1100, 3'b010, 2'b00, 2'b00, 2'b00, 1'b0);
        idle_in(); rsE = 5; regwriteW = 1; writeRegW = 5;
        step("lu_fwd_w", 4'b0000, 3'b000, 2'b00, 2'b01, 2'b00, 1'b0);
        idle_in(); memtoregE = 1; rtE = 9; rtD = 9; rsD = 2;
        step("lu_rt", 4'b1100, 3'b010, 2'b00, 2'b00, 2'b00, 1'b0);
        idle_in(); memtoregE = 1; rtE = 9; rsD = 1; rtD = 2;
        step("lu_none", 4'b0000, 3'b000, 2'b00, 2'b00, 2'b00, 1'b0);

        // Forwarding priority and the zero register.
        idle_in(); rsE = 3; rtE = 3; rsD = 3; rtD = 3;
        writeRegM = 3; writeRegW = 3; regwriteM = 1; regwriteW = 1;
        step("fwd_m_prio", 4'b0000, 3'b000, 2'b11, 2'b10, 2'b10, 1'b0);
        rsE = 0; rtE = 0; rsD = 0; rtD = 0; writeRegM = 0; writeRegW = 0;
        step("fwd_zero", 4'b0000, 3'b000, 2'b00, 2'b00, 2'b00, 1'b0);
        idle_in(); rsE = 3; rtE = 4; writeRegM = 3; writeRegW = 4; regwriteW = 1;
        step("fwd_w_only", 4'b0000, 3'b000, 2'b00, 2'b00, 2'b01, 1'b0);

        // Branch hazards and redirect.
        idle_in(); branchD = 1; regwriteE = 1; writeRegE = 7; rsD = 7; pcSrcD = 1;
        step("br_stall_e", 4'b1100, 3'b010, 2'b00, 2'b00, 2'b00, 1'b0);
        regwriteE = 0;
        step("br_taken", 4'b0000, 3'b100, 2'b00, 2'b00, 2'b00, 1'b0);
        idle_in(); branchD = 1; memtoregM = 1; writeRegM = 8; rtD = 8;
        step("br_stall_m", 4'b1100, 3'b010, 2'b00, 2'b00, 2'b00, 1'b0);
        idle_in(); branchD = 1; regwriteE = 1; writeRegE = 0; rsD = 0;
        step("br_r0", 4'b0000, 3'b000, 2'b00, 2'b00, 2'b00, 1'b0);
        idle_in(); jumpD = 1;
        step("jump", 4'b0000, 3'b100, 2'b00, 2'b00, 2'b00, 1'b0);

        // Zero-wait access, then a 3-cycle wait (memstall outranks load-use).
        idle_in(); memReqM = 1; dmem_ack = 1;
        step("mem_zw", 4'b0000, 3'b000, 2'b00, 2'b00, 2'b00, 1'b1);
        dmem_ack = 0; memtoregE = 1; rtE = 5; rsD = 5;
        step("mem_w1", 4'b1111, 3'b001, 2'b00, 2'b00, 2'b00, 1'b1);
        memtoregE = 0; rtE = 0; rsD = 0;
        step("mem_w2", 4'b1111, 3'b001, 2'b00, 2'b00, 2'b00, 1'b1);
        step("mem_w3", 4'b1111, 3'b001, 2'b00, 2'b00, 2'b00, 1'b1);
        dmem_ack = 1;
        step("mem_ack", 4'b0000, 3'b000, 2'b00, 2'b00, 2'b00, 1'b1);
        idle_in();
        step("mem_idle", 4'b0000, 3'b000, 2'b00, 2'b00, 2'b00, 1'b0);

        // Timeout after 4 request cycles; abort outranks load-use.
        memReqM = 1;
        step("to_1", 4'b1111, 3'b001, 2'b00, 2'b00, 2'b00, 1'b1);
        step("to_2", 4'b1111, 3'b001, 2'b00, 2'b00, 2'b00, 1'b1);
        step("to_3", 4'b1111, 3'b001, 2'b00, 2'b00, 2'b00, 1'b1);
        memtoregE = 1; rtE = 5; rsD = 5;
        step("to_abort", 4'b0000, 3'b001, 2'b00, 2'b00, 2'b00, 1'b1);
        exp_err = 1'b1;
        memtoregE = 0; rtE = 0; rsD = 0;
        step("to_fresh", 4'b1111, 3'b001, 2'b00, 2'b00, 2'b00, 1'b1);
        dmem_ack = 1;
        step("to_ack", 4'b0000, 3'b000, 2'b00, 2'b00, 2'b00, 1'b1);
        idle_in();
        step("to_sticky", 4'b0000, 3'b000, 2'b00, 2'b00, 2'b00, 1'b0);

        // Counter saturation under a held load-use stall.
        memtoregE = 1; rtE = 5; rsD = 5;
        for (int i = 0; i < 16; i++)
            step("sat", 4'b1100, 3'b010, 2'b00, 2'b00, 2'b00, 1'b0);

        // Reset asserted in the middle of a wait.
        idle_in(); memReqM = 1;
        step("rw_1", 4'b1111, 3'b001, 2'b00, 2'b00, 2'b00, 1'b1);
        step("rw_2", 4'b1111, 3'b001, 2'b00, 2'b00, 2'b00, 1'b1);
        #2;
        rst_n = 1'b0; memReqM = 0; exp_err = 1'b0; exp_cnt = 4'd0;
        step("rst_mid", 4'b0000, 3'b000, 2'b00, 2'b00, 2'b00, 1'b0);
        memReqM = 1;
        step("rst_req", 4'b1111, 3'b001, 2'b00, 2'b00, 2'b00, 1'b1);
        rst_n = 1'b1; dmem_ack = 1;
        step("rel_zw", 4'b0000, 3'b000, 2'b00, 2'b00, 2'b00, 1'b1);
        dmem_ack = 0;
        step("rel_w1", 4'b1111, 3'b001, 2'b00, 2'b00, 2'b00, 1'b1);
        step("rel_w2", 4'b1111, 3'b001, 2'b00, 2'b00, 2'b00, 1'b1);
        step("rel_w3", 4'b1111, 3'b001, 2'b00, 2'b00, 2'b00, 1'b1);
        step("rel_abort", 4'b0000, 3'b001, 2'b00, 2'b00, 2'b00, 1'b1);
        exp_err = 1'b1;
        idle_in();
        step("rel_end", 4'b0000, 3'b000, 2'b00, 2'b00, 2'b00, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
- Central hazard and stall controller for the 5-stage pipeline. Drives the stall (hold) and clr (flush) pins of the F/D, D/E, E/M and M/W latches and the D/E-stage forwarding muxes.
- Sequences variable-latency data-memory accesses in M through a req/ack handshake with timeout.
- Sits beside the datapath; consumes register indices and control bits already carried by the pipeline latches.

Parameters:
TIMEOUT, 64, max WAIT cycles before a data-memory access is aborted (>=2)
CNT_W, 32, width of the saturating stall-cycle counter

Ports:
clk  in  1  pipeline clock, rising edge
rst_n  in  1  asynchronous active-low reset
rsD, rtD, rsE, rtE  in  5 each  source registers in D and E
writeRegE, writeRegM, writeRegW  in  5 each  destination registers
regwriteE, regwriteM, regwriteW  in  1 each  register-write enables per stage
memtoregE, memtoregM  in  1 each  load in E / M
branchD, jumpD, pcSrcD  in  1 each  branch in D, jump in D, branch taken (resolved in D)
memReqM  in  1  M holds a load or store
dmem_ack  in  1  data memory completes access this cycle
dmem_req  out  1  data-memory request
stallF, stallD, stallE, stallM  out  1 each  hold PC and F/D, D/E, E/M latches
flushD, flushE, flushW  out  1 each  clear F/D, D/E, M/W latches at next edge
forwardAD, forwardBD  out  1 each  D-stage branch-compare forward from M
forwardAE, forwardBE  out  2 each  E-stage ALU forwarding: 00 reg file, 01 W result, 10 M aluOut
mem_err  out  1  sticky; a memory access timed out
stall_cnt  out  CNT_W  saturating count of cycles with stallF=1

Behaviour:
- Memory FSM states: IDLE, WAIT.
  - Reset: IDLE, wait counter 0, mem_err 0, stall_cnt 0.
- dmem_req = (IDLE & memReqM) | WAIT. It is combinational, so it is 0 in reset whenever memReqM=0.
- Zero-wait access: IDLE & memReqM & dmem_ack -> no stall, stay IDLE.
- Missed access: IDLE & memReqM & !dmem_ack -> WAIT at next edge, counter cleared.
- In WAIT the counter increments each cycle.
  - dmem_ack -> IDLE, counter 0.
  - abort = WAIT & !dmem_ack & counter==TIMEOUT-2 (TIMEOUT total request cycles) -> IDLE, mem_err<=1.
- memstall = dmem_req & !dmem_ack & !abort.
- lwstall = memtoregE & (rtE==rsD | rtE==rtD).
- brstall = branchD & ((regwriteE & writeRegE!=0 & (writeRegE==rsD | writeRegE==rtD)) | (memtoregM & writeRegM!=0 & (writeRegM==rsD | writeRegM==rtD))).
- Priority, evaluated every cycle:
  1. memstall: stallF=stallD=stallE=stallM=1, flushW=1, flushD=flushE=0. The whole front is frozen; W gets a bubble.
  2. abort: no stalls, flushW=1, so the aborted op never writes back.
  3. lwstall | brstall: stallF=stallD=1, flushE=1. flushD=0 even if pcSrcD/jumpD; the branch re-evaluates next cycle.
  4. pcSrcD | jumpD: flushD=1.
  5. Otherwise all stall/flush outputs 0.
- Forwarding, independent of stalls:
  - forwardAE=10 if rsE!=0 & regwriteM & rsE==writeRegM; else 01 if rsE!=0 & regwriteW & rsE==writeRegW; else 00. M has priority over W.
  - forwardBE: same rule with rtE.
  - forwardAD = rsD!=0 & regwriteM & rsD==writeRegM. forwardBD: same rule with rtD.
- stall_cnt increments on each edge with stallF=1 and saturates at all-ones.
- mem_err clears only on reset.
- Reset asserted mid-WAIT: return to IDLE immediately, dmem_req follows memReqM, and the pending access is discarded.
- Latency: all stall/flush/forward outputs are combinational, same cycle; FSM state and counters update on the rising edge.
- The pipeline latches gain a stall (enable-low) input. clr wins over stall.

Decomposition:
- Shared package pipe_pkg: forwarding select constants (FWD_RF=2'b00, FWD_WB=2'b01, FWD_MEM=2'b10), FSM state enum, REG_ZERO=5'd0.
- One sub-module: dmem_handshake_fsm. It holds the FSM, wait counter, abort and mem_err, and outputs dmem_req, memstall and abort.
- Hazard and forwarding logic stays in the top module.

Test Plan:
1. Load-use: memtoregE=1, rtE=5, rsD=5 -> stallF=stallD=flushE=1 for one cycle; next cycle forwardAE=01 for rsE=5 from W.
2. Forward priority: rsE=3, writeRegM=3, writeRegW=3, both regwrite=1 -> forwardAE=10. With rsE=0 -> 00.
3. Memory wait: memReqM=1, dmem_ack low for 3 cycles then high -> dmem_req high 4 cycles; all stalls and flushW high for 3 cycles, low in the ack cycle; stall_cnt +=3; state returns to IDLE.
4. Timeout: TIMEOUT=4, ack never arrives -> abort in 4th request cycle with flushW=1 and stalls 0; mem_err=1 and stays 1; next memReqM starts a fresh request.
5. Branch: branchD=1, regwriteE=1, writeRegE=rsD=7 -> stall one cycle. Then pcSrcD=1 -> flushD=1 the following cycle.
6. Reset in WAIT: drop rst_n mid-wait -> outputs return immediately to reset values with mem_err=0 and stall_cnt=0; after release with memReqM=1, dmem_req=1 from IDLE.
